fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC loaded by reset.
REQ-002 Parameter: NOP_INST, 32'h0000_0013 (addi x0,x0,0), instruction presented on a bubble.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 stall  in  1  hold PC and IF/ID register (load-use hazard from downstream).
REQ-006 flush  in  1  replace the IF/ID contents with a bubble next edge.
REQ-007 redirect_valid  in  1  taken branch/jump from execute.
REQ-008 redirect_pc  in  32  branch/jump target.
REQ-009 imem_addr  out  32  instruction memory address; equals current PC.
REQ-010 imem_rdata  in  32  instruction word for imem_addr, combinational same cycle.
REQ-011 if_id_inst  out  32  registered instruction feeding the control decoder (opcode = bits 6:0).
REQ-012 if_id_pc  out  32  registered PC of if_id_inst.
REQ-013 if_id_valid  out  1  if_id_inst is a real instruction.
REQ-014 fetch_count  out  32  number of valid instructions loaded into IF/ID.
REQ-015 fault  out  1  misaligned redirect detected; sticky until reset.

Function
REQ-016 FSM states BOOT, RUN, FAULT; BOOT follows reset.
REQ-017 BOOT -> RUN unconditionally after one cycle; no IF/ID capture and no PC change in BOOT.
REQ-018 In RUN, when no redirect, no flush and no stall, the next edge loads: PC <= PC+4, if_id_inst <= imem_rdata, if_id_pc <= PC, if_id_valid <= 1.
REQ-019 Latency: word at imem_addr=A appears on if_id_inst with if_id_pc=A one edge later.
REQ-020 PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0 with no flag.
REQ-021 Priority per edge: rst > redirect_valid > stall > flush.
REQ-022 redirect_valid in RUN with redirect_pc[1:0]==0: PC <= redirect_pc; IF/ID becomes bubble regardless of stall or flush.
REQ-023 redirect_valid in RUN with redirect_pc[1:0]!=0: go to FAULT; PC unchanged; IF/ID becomes bubble.
REQ-024 stall (no redirect): PC, if_id_inst, if_id_pc, if_id_valid all unchanged; flush ignored that cycle.
REQ-025 flush (no redirect, no stall): PC <= PC+4; IF/ID becomes bubble.
REQ-026 Bubble: if_id_inst = NOP_INST, if_id_valid = 0, if_id_pc unchanged.
REQ-027 FAULT: fault=1; PC frozen; IF/ID held as bubble; all inputs except rst ignored; exit only via rst.
REQ-028 fetch_count increments by 1 exactly on edges where if_id_valid is loaded with 1; wraps FFFF_FFFF -> 0.
REQ-029 imem_addr shall be PC directly (no combinational path from redirect_pc or stall).
REQ-030 redirect_valid, stall and flush shall be ignored in BOOT.

Reset
REQ-031 On rst edge: state=BOOT, PC=RESET_PC, if_id_inst=NOP_INST, if_id_pc=RESET_PC, if_id_valid=0, fetch_count=0, fault=0.
REQ-032 rst asserted mid-operation (including during stall or FAULT) shall override all other inputs that edge and discard any in-flight redirect.

Structure
REQ-033 Shared package holds the state enumeration (BOOT/RUN/FAULT), NOP_INST and the instruction/address width constant (32).
REQ-034 A single sub-module, if_id_reg, shall hold the IF/ID register with load/hold/bubble controls; PC, FSM and counter live in fetch_stage.

Verification
REQ-035 Reset, imem returns A+0x100 for address A, 4 free-running cycles -> if_id_pc 0,4,8 with if_id_inst 0x100,0x104,0x108; fetch_count=3.
REQ-036 stall high 2 cycles while if_id_pc=0x8 -> if_id_pc stays 0x8, imem_addr stays 0xC, fetch_count unchanged; resumes at 0xC.
REQ-037 redirect_valid=1, redirect_pc=0x40, with stall=1 at the same edge -> imem_addr=0x40, if_id_valid=0, if_id_inst=0x0000_0013; next edge if_id_pc=0x40.
REQ-038 redirect_pc=0x42 -> fault=1, if_id_valid=0, PC frozen for 5 cycles despite stall/flush toggling; rst clears fault and PC=0.
REQ-039 Force PC to 0xFFFF_FFFC via redirect -> next imem_addr=0x0000_0000, fault=0.
REQ-040 rst asserted on same edge as redirect_valid to 0x80 -> PC=RESET_PC, state BOOT, if_id_valid=0 for two cycles.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_FAULT
  } state_e;

  // Instruction word together with the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } if_id_t;

  // Instructions are word aligned; any low address bit set is a bad target.
  function automatic logic is_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Control, instruction-memory and IF/ID signals of the fetch stage.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic            stall;
  logic            flush;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] if_id_inst;
  logic [XLEN-1:0] if_id_pc;
  logic            if_id_valid;
  logic [XLEN-1:0] fetch_count;
  logic            fault;

  // Fetch stage side.
  modport master (
    input  stall, flush, redirect_valid, redirect_pc, imem_rdata,
    output imem_addr, if_id_inst, if_id_pc, if_id_valid, fetch_count, fault
  );

  // Surrounding pipeline / memory side.
  modport slave (
    output stall, flush, redirect_valid, redirect_pc, imem_rdata,
    input  imem_addr, if_id_inst, if_id_pc, if_id_valid, fetch_count, fault
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load a fetched word, hold, or collapse to a bubble.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = fetch_stage_pkg::NOP_INST
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load_i,
  input  logic   bubble_i,
  input  if_id_t payload_i,
  output if_id_t payload_o,
  output logic   valid_o
);

  if_id_t payload_q, payload_d;
  logic   valid_q, valid_d;

  // Bubble wins over load; a bubble keeps the previous PC.
  always_comb begin
    payload_d = payload_q;
    valid_d   = valid_q;
    if (bubble_i) begin
      payload_d.inst = NOP_INST;
      valid_d        = 1'b0;
    end else if (load_i) begin
      payload_d = payload_i;
      valid_d   = 1'b1;
    end
  end

  // Register update with synchronous reset to a bubble at RESET_PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      payload_q.inst <= NOP_INST;
      payload_q.pc   <= RESET_PC;
      valid_q        <= 1'b0;
    end else begin
      payload_q <= payload_d;
      valid_q   <= valid_d;
    end
  end

  assign payload_o = payload_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, BOOT/RUN/FAULT control and fetch counter.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = fetch_stage_pkg::NOP_INST
) (
  input logic         clk,
  input logic         rst,
  fetch_stage_if.master bus
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] count_q, count_d;
  logic            fault_q, fault_d;
  logic            id_load, id_bubble;
  if_id_t          id_in, id_out;

  // Next-state and IF/ID control; priority redirect > stall > flush.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    count_d   = count_q;
    id_load   = 1'b0;
    id_bubble = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (bus.redirect_valid) begin
          id_bubble = 1'b1;
          if (is_aligned(bus.redirect_pc)) begin
            pc_d = bus.redirect_pc;
          end else begin
            state_d = ST_FAULT;
          end
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else if (bus.flush) begin
          pc_d      = pc_q + XLEN'(4);
          id_bubble = 1'b1;
        end else begin
          pc_d    = pc_q + XLEN'(4);
          id_load = 1'b1;
          count_d = count_q + XLEN'(1);
        end
      end
      ST_FAULT: id_bubble = 1'b1;
      default:  state_d = ST_BOOT;
    endcase
    fault_d = (state_d == ST_FAULT);
  end

  // State, PC, counter and sticky fault flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      count_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      fault_q <= fault_d;
    end
  end

  assign id_in.inst = bus.imem_rdata;
  assign id_in.pc   = pc_q;

  if_id_reg #(
    .RESET_PC (RESET_PC),
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .load_i    (id_load),
    .bubble_i  (id_bubble),
    .payload_i (id_in),
    .payload_o (id_out),
    .valid_o   (bus.if_id_valid)
  );

  assign bus.imem_addr   = pc_q;
  assign bus.if_id_inst  = id_out.inst;
  assign bus.if_id_pc    = id_out.pc;
  assign bus.fetch_count = count_q;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios plus random traffic.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam int M_BOOT  = 0;
  localparam int M_RUN   = 1;
  localparam int M_FAULT = 2;

  logic clk;
  logic rst;
  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Instruction memory: word at address A is A+0x100.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a + 32'h100;
  endfunction

  assign bus.imem_rdata = mem(bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] cnt;
    logic        flt;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state.
  int          m_mode = M_BOOT;
  logic [31:0] m_pc = 0, m_inst = 0, m_ipc = 0, m_cnt = 0;
  logic        m_valid = 0, m_flt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge of the fetch stage as described by its rules.
  task automatic model(input logic r, input logic rv, input logic [31:0] rp,
                       input logic st, input logic fl);
    if (r) begin
      m_mode = M_BOOT; m_pc = RST_PC; m_inst = NOP; m_ipc = RST_PC;
      m_valid = 0; m_cnt = 0; m_flt = 0;
    end else if (m_mode == M_BOOT) begin
      m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (rv) begin
        if (rp % 4 == 0) m_pc = rp;
        else begin m_mode = M_FAULT; m_flt = 1; end
        m_inst = NOP; m_valid = 0;
      end else if (st) begin
        // everything holds
      end else if (fl) begin
        m_pc = m_pc + 4; m_inst = NOP; m_valid = 0;
      end else begin
        m_inst = mem(m_pc); m_ipc = m_pc; m_valid = 1;
        m_pc = m_pc + 4; m_cnt = m_cnt + 1;
      end
    end
  endtask

  // Drive one cycle of inputs and queue the state expected after the edge.
  task automatic step(input logic r, input logic rv, input logic [31:0] rp,
                      input logic st, input logic fl);
    exp_t e;
    @(negedge clk);
    rst = r; bus.redirect_valid = rv; bus.redirect_pc = rp;
    bus.stall = st; bus.flush = fl;
    model(r, rv, rp, st, fl);
    e.addr = m_pc; e.inst = m_inst; e.pc = m_ipc;
    e.valid = m_valid; e.cnt = m_cnt; e.flt = m_flt;
    exp_q.push_back(e);
  endtask

  task automatic free();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic post();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_imem_addr", bus.imem_addr, e.addr);
        chk("sb_if_id_inst", bus.if_id_inst, e.inst);
        chk("sb_if_id_pc", bus.if_id_pc, e.pc);
        chk("sb_if_id_valid", 32'(bus.if_id_valid), 32'(e.valid));
        chk("sb_fetch_count", bus.fetch_count, e.cnt);
        chk("sb_fault", 32'(bus.fault), 32'(e.flt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r, rv, st, fl;
    logic [31:0] rp;
    rst = 1'b1; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus.stall = 1'b0; bus.flush = 1'b0;

    // Reset values, BOOT cycle, then three loads.
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0); post();
    chk("rst_valid", 32'(bus.if_id_valid), 32'd0);
    chk("rst_inst", bus.if_id_inst, NOP);
    chk("rst_count", bus.fetch_count, 32'd0);
    chk("rst_fault", 32'(bus.fault), 32'd0);
    free(); post();
    chk("boot_no_pc_change", bus.imem_addr, 32'h0);
    chk("boot_no_capture", 32'(bus.if_id_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      free(); post();
      chk("run_if_id_pc", bus.if_id_pc, 32'(i * 4));
      chk("run_if_id_inst", bus.if_id_inst, 32'(32'h100 + i * 4));
    end
    chk("run_count3", bus.fetch_count, 32'd3);

    // Stall holds everything for two cycles.
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1); post();
      chk("stall_if_id_pc", bus.if_id_pc, 32'h8);
      chk("stall_imem_addr", bus.imem_addr, 32'hC);
      chk("stall_count", bus.fetch_count, 32'd3);
    end
    free(); post();
    chk("resume_if_id_pc", bus.if_id_pc, 32'hC);

    // Redirect beats a simultaneous stall.
    step(1'b0, 1'b1, 32'h40, 1'b1, 1'b0); post();
    chk("redir_imem_addr", bus.imem_addr, 32'h40);
    chk("redir_valid", 32'(bus.if_id_valid), 32'd0);
    chk("redir_inst", bus.if_id_inst, NOP);
    free(); post();
    chk("redir_if_id_pc", bus.if_id_pc, 32'h40);

    // PC wraps past the top of the address space without a fault.
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0); post();
    free(); post();
    chk("wrap_imem_addr", bus.imem_addr, 32'h0);
    chk("wrap_fault", 32'(bus.fault), 32'd0);
    chk("wrap_inst", bus.if_id_inst, 32'h0000_00FC);
    free(); free(); post();

    // Misaligned redirect freezes in FAULT until reset.
    step(1'b0, 1'b1, 32'h42, 1'b0, 1'b0); post();
    chk("fault_set", 32'(bus.fault), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'(i % 2), 32'h100, 1'(i % 2), 1'(~i % 2)); post();
      chk("fault_pc_frozen", bus.imem_addr, 32'h8);
      chk("fault_bubble", 32'(bus.if_id_valid), 32'd0);
    end
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0); post();
    chk("fault_cleared", 32'(bus.fault), 32'd0);
    chk("fault_rst_pc", bus.imem_addr, RST_PC);

    // Reset on the same edge as a redirect discards it.
    free(); free(); free();
    step(1'b1, 1'b1, 32'h80, 1'b0, 1'b0); post();
    chk("rst_redir_pc", bus.imem_addr, RST_PC);
    free(); post();
    chk("rst_redir_boot_valid", 32'(bus.if_id_valid), 32'd0);
    chk("rst_redir_boot_pc", bus.imem_addr, RST_PC);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      r  = ($urandom_range(0, 39) == 0);
      rv = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) rp = $urandom() | 32'h1;
      else if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
      else rp = $urandom() & 32'hFFFF_FFFC;
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 4) == 0);
      step(r, rv, rp, st, fl);
    end

    @(negedge clk);
    bus.redirect_valid = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0; rst = 1'b0;
    post(); post();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
